// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
//  Module   : seq_alu
//  Purpose  : Parametrised multi-cycle ALU for the EX stage. Logic ops, shifts,
//             signed set-less-than and add/sub finish in one cycle; multiply
//             (shift-add) and unsigned divide/remainder (restoring) take one
//             bit per cycle for W cycles. Valid/ready handshake on both sides.
//  Ports    : clk        rising-edge clock
//             rst_n      synchronous reset, active low
//             in_valid   op, a, b valid          in_ready   can accept an op
//             op[3:0]    operation code          a, b       operands (W bits)
//             out_valid  result and flags valid  out_ready  consumer takes result
//             result     result (W bits)         zero       result == 0
//             ovf        signed overflow (ADD/SUB only)
//             dbz        divide by zero (DIVU/REMU only)
//  Revision : 1.0  initial release
// ============================================================================
module seq_alu #(
    parameter int W     = 32,
    parameter int CNT_W = $clog2(W) + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         zero,
    output logic         ovf,
    output logic         dbz
);

    localparam int c_SH_W = $clog2(W);

    localparam logic [3:0] c_OP_AND  = 4'b0000;
    localparam logic [3:0] c_OP_OR   = 4'b0001;
    localparam logic [3:0] c_OP_XOR  = 4'b0010;
    localparam logic [3:0] c_OP_NOR  = 4'b0011;
    localparam logic [3:0] c_OP_SLT  = 4'b0100;
    localparam logic [3:0] c_OP_NAND = 4'b0101;
    localparam logic [3:0] c_OP_SLL  = 4'b0110;
    localparam logic [3:0] c_OP_SRL  = 4'b0111;
    localparam logic [3:0] c_OP_ADD  = 4'b1000;
    localparam logic [3:0] c_OP_SUB  = 4'b1001;
    localparam logic [3:0] c_OP_MUL  = 4'b1010;
    localparam logic [3:0] c_OP_DIVU = 4'b1011;
    localparam logic [3:0] c_OP_REMU = 4'b1100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Iteration registers, shared between multiply and divide:
    //   MUL : r_opa = shifting multiplicand, r_opb = shifting multiplier,
    //         r_acc[W-1:0] = partial product
    //   DIV : r_opa = dividend shifting out / quotient shifting in,
    //         r_opb = divisor, r_acc = partial remainder (one guard bit)
    logic [W-1:0]     r_opa;
    logic [W-1:0]     r_opb;
    logic [W:0]       r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_is_mul;
    logic             r_is_divu;

    logic [W-1:0]     r_result;
    logic             r_zero;
    logic             r_ovf;
    logic             r_dbz;

    logic             w_accept;
    logic             w_b_zero;
    logic             w_multi;
    logic             w_iter_last;
    logic [W-1:0]     w_sum;
    logic [W-1:0]     w_dif;
    logic [W-1:0]     w_single;
    logic             w_single_ovf;
    logic             w_single_dbz;
    logic [W-1:0]     w_mul_acc;
    logic [W:0]       w_rem_sh;
    logic [W:0]       w_rem_try;
    logic [W:0]       w_rem_next;
    logic [W-1:0]     w_quo_next;
    logic [W-1:0]     w_div_res;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;
    assign zero      = r_zero;
    assign ovf       = r_ovf;
    assign dbz       = r_dbz;

    assign w_accept    = in_valid & in_ready;
    assign w_b_zero    = (b == '0);
    // A zero divisor skips iteration and completes like a single-cycle op
    assign w_multi     = (op == c_OP_MUL) |
                         (((op == c_OP_DIVU) | (op == c_OP_REMU)) & ~w_b_zero);
    assign w_iter_last = (r_cnt == CNT_W'(W - 1));

    // ------------------------------------------------------------------
    // Single-cycle datapath, evaluated on the live inputs at accept
    // ------------------------------------------------------------------
    assign w_sum = a + b;
    assign w_dif = a - b;

    always_comb begin
        w_single     = a;
        w_single_ovf = 1'b0;
        w_single_dbz = 1'b0;
        case (op)
            c_OP_AND:  w_single = a & b;
            c_OP_OR:   w_single = a | b;
            c_OP_XOR:  w_single = a ^ b;
            c_OP_NOR:  w_single = ~(a | b);
            c_OP_SLT:  w_single = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
            c_OP_NAND: w_single = ~(a & b);
            c_OP_SLL:  w_single = a << b[c_SH_W-1:0];
            c_OP_SRL:  w_single = a >> b[c_SH_W-1:0];
            c_OP_ADD: begin
                w_single     = w_sum;
                w_single_ovf = (a[W-1] == b[W-1]) & (w_sum[W-1] != a[W-1]);
            end
            c_OP_SUB: begin
                w_single     = w_dif;
                w_single_ovf = (a[W-1] != b[W-1]) & (w_dif[W-1] != a[W-1]);
            end
            c_OP_MUL:  w_single = '0;
            c_OP_DIVU: begin
                w_single     = '1;
                w_single_dbz = w_b_zero;
            end
            c_OP_REMU: begin
                w_single     = a;
                w_single_dbz = w_b_zero;
            end
            default:   w_single = a;
        endcase
    end

    // ------------------------------------------------------------------
    // Iterative datapath: one multiplier bit / one quotient bit per cycle
    // ------------------------------------------------------------------
    assign w_mul_acc  = r_acc[W-1:0] + (r_opb[0] ? r_opa : '0);

    assign w_rem_sh   = {r_acc[W-1:0], r_opa[W-1]};
    assign w_rem_try  = w_rem_sh - {1'b0, r_opb};
    // Borrow out of the guard bit means the divisor did not fit: restore
    assign w_rem_next = w_rem_try[W] ? w_rem_sh : w_rem_try;
    assign w_quo_next = {r_opa[W-2:0], ~w_rem_try[W]};
    assign w_div_res  = r_is_divu ? w_quo_next : w_rem_next[W-1:0];

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = w_multi ? S_BUSY : S_DONE;
                end
            end
            S_BUSY: begin
                if (w_iter_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_opa     <= '0;
            r_opb     <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_is_mul  <= 1'b0;
            r_is_divu <= 1'b0;
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_ovf     <= 1'b0;
            r_dbz     <= 1'b0;
        end else if (w_accept) begin
            r_opa     <= a;
            r_opb     <= b;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_is_mul  <= (op == c_OP_MUL);
            r_is_divu <= (op == c_OP_DIVU);
            if (!w_multi) begin
                r_result <= w_single;
                r_zero   <= (w_single == '0);
                r_ovf    <= w_single_ovf;
                r_dbz    <= w_single_dbz;
            end
        end else if (r_state == S_BUSY) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_is_mul) begin
                r_acc <= {1'b0, w_mul_acc};
                r_opa <= r_opa << 1;
                r_opb <= r_opb >> 1;
                if (w_iter_last) begin
                    r_result <= w_mul_acc;
                    r_zero   <= (w_mul_acc == '0);
                    r_ovf    <= 1'b0;
                    r_dbz    <= 1'b0;
                end
            end else begin
                r_acc <= w_rem_next;
                r_opa <= w_quo_next;
                if (w_iter_last) begin
                    r_result <= w_div_res;
                    r_zero   <= (w_div_res == '0);
                    r_ovf    <= 1'b0;
                    r_dbz    <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_alu
//  Purpose  : Self-checking bench for seq_alu (W=32). Table of directed
//             vectors with hand-computed results plus hand-written sequences
//             for back-pressure and reset during an iterative op.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq_alu;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         ovf;
    logic         dbz;

    int n_checks = 0;
    int n_errors = 0;

    seq_alu #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .ovf       (ovf),
        .dbz       (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        o;
        logic        d;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] f_op, input logic [31:0] f_a,
                                input logic [31:0] f_b, input logic [31:0] f_res,
                                input logic f_z, input logic f_o, input logic f_d,
                                input int f_lat);
        vec_t v;
        v.op = f_op; v.a = f_a; v.b = f_b; v.res = f_res;
        v.z = f_z; v.o = f_o; v.d = f_d; v.lat = f_lat;
        return v;
    endfunction

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Issue one op; returns cycles from accept to out_valid and whether
    // in_ready was seen high while waiting. Operands are scrambled after
    // accept so any late sampling shows up as a wrong result.
    task automatic do_op(input logic [3:0] f_op, input logic [31:0] f_a,
                         input logic [31:0] f_b, output int lat, output logic ir_seen);
        int n;
        n       = 0;
        ir_seen = 1'b0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        in_valid = 1'b1;
        op       = f_op;
        a        = f_a;
        b        = f_b;
        tick();
        in_valid = 1'b0;
        op       = 4'($urandom);
        a        = $urandom;
        b        = $urandom;
        lat      = 1;
        while (!out_valid && lat < 100) begin
            if (in_ready) ir_seen = 1'b1;
            tick();
            lat++;
        end
    endtask

    task automatic release_result(input string name);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({name, "_ovalid_drop"}, 64'(out_valid), 64'd0);
        chk({name, "_iready_back"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        int          lat;
        logic        ir_seen;
        logic [31:0] held;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 4'h0;
        a         = '0;
        b         = '0;

        // Single-cycle ops (latency 1)
        vecs.push_back(mk(4'h8, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 1, 0, 1));
        vecs.push_back(mk(4'h9, 32'h00000005, 32'h00000005, 32'h00000000, 1, 0, 0, 1));
        vecs.push_back(mk(4'h4, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 0, 0, 0, 1));
        vecs.push_back(mk(4'h4, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1, 0, 0, 1));
        vecs.push_back(mk(4'h0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 0, 0, 0, 1));
        vecs.push_back(mk(4'h1, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 0, 0, 0, 1));
        vecs.push_back(mk(4'h2, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 0, 0, 0, 1));
        vecs.push_back(mk(4'h3, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h000F000F, 0, 0, 0, 1));
        vecs.push_back(mk(4'h5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1, 0, 0, 1));
        vecs.push_back(mk(4'h6, 32'h00000001, 32'h00000023, 32'h00000008, 0, 0, 0, 1));
        vecs.push_back(mk(4'h7, 32'h80000000, 32'h0000001F, 32'h00000001, 0, 0, 0, 1));
        vecs.push_back(mk(4'h7, 32'h80000000, 32'h00000020, 32'h80000000, 0, 0, 0, 1));
        vecs.push_back(mk(4'h9, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 0, 1, 0, 1));
        vecs.push_back(mk(4'h9, 32'h00000000, 32'h80000000, 32'h80000000, 0, 1, 0, 1));
        vecs.push_back(mk(4'h8, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 0, 0, 1));
        vecs.push_back(mk(4'hD, 32'h12345678, 32'hFFFFFFFF, 32'h12345678, 0, 0, 0, 1));
        vecs.push_back(mk(4'hF, 32'h00000000, 32'h00000001, 32'h00000000, 1, 0, 0, 1));
        // Divide by zero: no iteration
        vecs.push_back(mk(4'hB, 32'h00000009, 32'h00000000, 32'hFFFFFFFF, 0, 0, 1, 1));
        vecs.push_back(mk(4'hC, 32'h0000004D, 32'h00000000, 32'h0000004D, 0, 0, 1, 1));
        // Iterative ops (latency W+1)
        vecs.push_back(mk(4'hA, 32'h00010000, 32'h00010000, 32'h00000000, 1, 0, 0, 33));
        vecs.push_back(mk(4'hA, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 0, 0, 0, 33));
        vecs.push_back(mk(4'hA, 32'h00001234, 32'h00000100, 32'h00123400, 0, 0, 0, 33));
        vecs.push_back(mk(4'hB, 32'h00000064, 32'h00000007, 32'h0000000E, 0, 0, 0, 33));
        vecs.push_back(mk(4'hC, 32'h00000064, 32'h00000007, 32'h00000002, 0, 0, 0, 33));
        vecs.push_back(mk(4'hB, 32'hFFFFFFFF, 32'h00000002, 32'h7FFFFFFF, 0, 0, 0, 33));
        vecs.push_back(mk(4'hC, 32'hFFFFFFFF, 32'h0000000A, 32'h00000005, 0, 0, 0, 33));
        vecs.push_back(mk(4'hB, 32'h00000005, 32'h00000007, 32'h00000000, 1, 0, 0, 33));

        // ---------------- reset state ----------------
        repeat (3) tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result",    64'(result),    64'd0);
        chk("rst_flags",     64'({zero, ovf, dbz}), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready",  64'(in_ready),  64'd1);

        // ---------------- table ----------------
        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, ir_seen);
            chk($sformatf("v%0d_lat", i),    64'(lat),    64'(vecs[i].lat));
            chk($sformatf("v%0d_iready", i), 64'(ir_seen), 64'd0);
            chk($sformatf("v%0d_result", i), 64'(result), 64'(vecs[i].res));
            chk($sformatf("v%0d_flags", i),  64'({zero, ovf, dbz}),
                64'({vecs[i].z, vecs[i].o, vecs[i].d}));
            release_result($sformatf("v%0d", i));
        end

        // ---------------- back-pressure: SLL 1<<35 held 5 cycles ----------------
        do_op(4'h6, 32'h1, 32'd35, lat, ir_seen);
        chk("hold_lat", 64'(lat), 64'd1);
        held = 32'h8;
        for (int k = 0; k < 5; k++) begin
            // A competing request while DONE must not be taken
            in_valid = 1'b1;
            op       = 4'h8;
            a        = 32'h11;
            b        = 32'h22;
            tick();
            chk($sformatf("hold%0d_result", k), 64'(result),    64'(held));
            chk($sformatf("hold%0d_ovalid", k), 64'(out_valid), 64'd1);
            chk($sformatf("hold%0d_iready", k), 64'(in_ready),  64'd0);
        end
        in_valid = 1'b0;
        release_result("hold");

        // ---------------- out_ready while idle is ignored ----------------
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        chk("idle_ordy_iready", 64'(in_ready), 64'd1);
        chk("idle_ordy_ovalid", 64'(out_valid), 64'd0);

        // ---------------- reset mid-BUSY aborts DIVU ----------------
        in_valid = 1'b1;
        op       = 4'hB;
        a        = 32'd100;
        b        = 32'd7;
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        chk("abort_busy_iready", 64'(in_ready), 64'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_result", 64'(result), 64'd0);
        chk("abort_flags",  64'({zero, ovf, dbz}), 64'd0);
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 40; k++) begin
                if (out_valid) seen++;
                tick();
            end
            chk("abort_no_ovalid", 64'(seen), 64'd0);
        end
        chk("abort_iready", 64'(in_ready), 64'd1);
        do_op(4'h8, 32'd2, 32'd3, lat, ir_seen);
        chk("post_abort_lat",    64'(lat),    64'd1);
        chk("post_abort_result", 64'(result), 64'd5);
        chk("post_abort_flags",  64'({zero, ovf, dbz}), 64'd0);
        release_result("post_abort");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
